// File: rtl/oam_dma_arbiter_pkg.sv
// Shared CPU-side types: DMA sequencing state, CPU access routing and the
// OAM DMA register constants.
package oam_dma_arbiter_pkg;

    typedef enum logic [1:0] {
        DMA_IDLE     = 2'd0,
        DMA_STARTING = 2'd1,
        DMA_ACTIVE   = 2'd2
    } dma_state_t;

    typedef enum logic [2:0] {
        ROUTE_NONE    = 3'd0,
        ROUTE_DMA_REG = 3'd1,
        ROUTE_IO      = 3'd2,
        ROUTE_BUS     = 3'd3,
        ROUTE_BLOCKED = 3'd4
    } cpu_route_t;

    localparam logic [15:0] DMA_REG_ADDR   = 16'hFF46;
    localparam int          DMA_LENGTH     = 160;
    localparam logic [7:0]  DMA_LAST_INDEX = 8'(DMA_LENGTH - 1);
    localparam logic [7:0]  HIGH_PAGE      = 8'hFF;
    localparam logic [7:0]  OPEN_BUS       = 8'hFF;
    localparam logic [7:0]  SRC_RESET      = 8'hFF;

    // Source pages E0..FF mirror down onto C0..DF (echo RAM).
    function automatic logic [7:0] dma_src_page(input logic [7:0] src);
        return (src >= 8'hE0) ? (src - 8'h20) : src;
    endfunction

endpackage

// File: rtl/oam_dma_arbiter_if.sv
// CPU, external bus, high-page I/O and OAM write signals of the arbiter.
// slave: arbiter side; master: the surrounding system (CPU, memories, I/O).
interface oam_dma_arbiter_if;

    logic        cpu_mem_enable;
    logic        cpu_mem_write;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_out;
    logic [7:0]  cpu_data_in;

    logic        bus_enable;
    logic        bus_write;
    logic [15:0] bus_addr;
    logic [7:0]  bus_data_out;
    logic [7:0]  bus_data_in;

    logic        io_enable;
    logic        io_write;
    logic [7:0]  io_addr;
    logic [7:0]  io_data_out;
    logic [7:0]  io_data_in;

    logic        oam_write;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_data;

    modport slave (
        input  cpu_mem_enable, cpu_mem_write, cpu_addr, cpu_data_out,
        output cpu_data_in,
        output bus_enable, bus_write, bus_addr, bus_data_out,
        input  bus_data_in,
        output io_enable, io_write, io_addr, io_data_out,
        input  io_data_in,
        output oam_write, oam_addr, oam_data
    );

    modport master (
        output cpu_mem_enable, cpu_mem_write, cpu_addr, cpu_data_out,
        input  cpu_data_in,
        input  bus_enable, bus_write, bus_addr, bus_data_out,
        output bus_data_in,
        input  io_enable, io_write, io_addr, io_data_out,
        output io_data_in,
        input  oam_write, oam_addr, oam_data
    );

endinterface

// File: rtl/oam_dma_arbiter.sv
// OAM DMA engine and CPU/DMA bus arbiter.
//
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   DMA_IDLE     | no transfer; CPU owns the external bus
//   DMA_STARTING | one M-cycle of setup after a FF46 write; CPU still owns bus
//   DMA_ACTIVE   | byte k copied from {src_page,k} to OAM[k]; CPU below FF00
//                | is blocked
//
// State, byte counter and source register only advance on M-cycle ends
// (clk edges with t_cycle==3). A FF46 write in any state restarts the
// sequence from DMA_STARTING.
module oam_dma_arbiter
    import oam_dma_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        t_cycle,
    output logic              dma_active,
    oam_dma_arbiter_if.slave  mem
);

    dma_state_t state;
    dma_state_t state_nxt;
    logic [7:0] count;
    logic [7:0] count_nxt;
    logic [7:0] src;
    logic [7:0] src_nxt;
    logic       m_end;
    logic       dma_trigger;
    cpu_route_t route;

    assign m_end       = (t_cycle == 2'd3);
    assign dma_trigger = m_end & mem.cpu_mem_enable & mem.cpu_mem_write &
                         (mem.cpu_addr == DMA_REG_ADDR);

    // State, counter and source register; reset aborts any transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= DMA_IDLE;
            count <= 8'h00;
            src   <= SRC_RESET;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            src   <= src_nxt;
        end
    end

    // Next state: a trigger always wins and restarts the transfer.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        src_nxt   = src;
        if (dma_trigger) begin
            state_nxt = DMA_STARTING;
            count_nxt = 8'h00;
            src_nxt   = mem.cpu_data_out;
        end else if (m_end) begin
            case (state)
                DMA_IDLE: begin
                    state_nxt = DMA_IDLE;
                end
                DMA_STARTING: begin
                    state_nxt = DMA_ACTIVE;
                    count_nxt = 8'h00;
                end
                DMA_ACTIVE: begin
                    if (count == DMA_LAST_INDEX) begin
                        state_nxt = DMA_IDLE;
                        count_nxt = 8'h00;
                    end else begin
                        count_nxt = count + 8'd1;
                    end
                end
                default: begin
                    state_nxt = DMA_IDLE;
                    count_nxt = 8'h00;
                end
            endcase
        end
    end

    // Outputs: DMA bus ownership first, then CPU routing on top of it.
    always_comb begin
        route            = ROUTE_NONE;
        dma_active       = (state != DMA_IDLE);
        mem.bus_enable   = 1'b0;
        mem.bus_write    = 1'b0;
        mem.bus_addr     = 16'h0000;
        mem.bus_data_out = 8'h00;
        mem.io_enable    = 1'b0;
        mem.io_write     = 1'b0;
        mem.io_addr      = 8'h00;
        mem.io_data_out  = 8'h00;
        mem.oam_write    = 1'b0;
        mem.oam_addr     = 8'h00;
        mem.oam_data     = 8'h00;
        mem.cpu_data_in  = mem.bus_data_in;

        if (mem.cpu_mem_enable) begin
            if (mem.cpu_addr == DMA_REG_ADDR) begin
                route = ROUTE_DMA_REG;
            end else if (mem.cpu_addr[15:8] == HIGH_PAGE) begin
                route = ROUTE_IO;
            end else if (state == DMA_ACTIVE) begin
                route = ROUTE_BLOCKED;
            end else begin
                route = ROUTE_BUS;
            end
        end

        if (state == DMA_ACTIVE) begin
            mem.bus_enable = 1'b1;
            mem.bus_addr   = {dma_src_page(src), count};
            if (m_end) begin
                mem.oam_write = 1'b1;
                mem.oam_addr  = count;
                mem.oam_data  = mem.bus_data_in;
            end
        end

        case (route)
            ROUTE_DMA_REG: begin
                mem.cpu_data_in = src;
            end
            ROUTE_IO: begin
                mem.io_enable   = 1'b1;
                mem.io_write    = mem.cpu_mem_write;
                mem.io_addr     = mem.cpu_addr[7:0];
                mem.io_data_out = mem.cpu_mem_write ? mem.cpu_data_out : 8'h00;
                mem.cpu_data_in = mem.io_data_in;
            end
            ROUTE_BUS: begin
                mem.bus_enable   = 1'b1;
                mem.bus_write    = mem.cpu_mem_write;
                mem.bus_addr     = mem.cpu_addr;
                mem.bus_data_out = mem.cpu_mem_write ? mem.cpu_data_out : 8'h00;
                mem.cpu_data_in  = mem.bus_data_in;
            end
            ROUTE_BLOCKED: begin
                mem.cpu_data_in = OPEN_BUS;
            end
            default: begin
                mem.cpu_data_in = mem.bus_data_in;
            end
        endcase
    end

endmodule
